// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper. Optional feature macro used by the top: SUB_OVF_EN.
package serial_sub_pkg;

    // Controller states; the encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2 with a floor of one bit, so a 2-bit operand still gets a counter bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: in1 - in2 - bin, producing the difference bit and
// the borrow out. Purely combinational.
module full_subtractor (
    input  logic in1,
    input  logic in2,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic w_x;

    // Difference and borrow-out for a single bit position.
    always_comb begin
        w_x  = in1 ^ in2;
        diff = w_x ^ bin;
        bout = (~in1 & in2) | (~w_x & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first, one bit per
// clock, through a single full subtractor and one borrow flip-flop.
// Optional feature: define SUB_OVF_EN to add the two's-complement overflow
// output ovf (and the operand sign captures it needs).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    // Only the upper WIDTH-1 result bits need storage: the bit produced on the
    // final shift goes straight into the result register.
    logic [WIDTH-2:0]   r_d_sr;
    logic               r_bff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
`ifdef SUB_OVF_EN
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_ovf;
`endif

    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_diff_next;

    full_subtractor u_fs (
        .in1  (r_a_sr[0]),
        .in2  (r_b_sr[0]),
        .bin  (r_bff),
        .diff (w_d),
        .bout (w_bout)
    );

    // Result shift register after this cycle's bit is inserted at the top.
    assign w_diff_next = {w_d, r_d_sr};

    // Controller and datapath: load on start, shift WIDTH times, publish result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_bff    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_d_sr  <= '0;
                        r_bff   <= 1'b0;
                        r_cnt   <= '0;
`ifdef SUB_OVF_EN
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
`endif
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_d_sr <= w_diff_next[WIDTH-1:1];
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bff  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_diff   <= w_diff_next;
                        r_borrow <= w_bout;
`ifdef SUB_OVF_EN
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
`endif
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
`ifdef SUB_OVF_EN
    assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor. Honours SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int     WIDTH = 14;
    localparam longint MOD   = longint'(1) << WIDTH;
    localparam longint HALF  = MOD / 2;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    logic fs_in1 = 1'b0;
    logic fs_in2 = 1'b0;
    logic fs_bin = 1'b0;
    logic fs_diff;
    logic fs_bout;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bw;
        logic             ov;
        int               done_edge;
    } exp_t;

    exp_t             sbq[$];
    int               checks    = 0;
    int               failures  = 0;
    int               edge_cnt  = 0;
    int               free_edge = 0;
    logic [WIDTH-1:0] last_diff   = '0;
    logic             last_borrow = 1'b0;
    logic             last_ovf    = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    full_subtractor u_fs_ut (
        .in1  (fs_in1),
        .in2  (fs_in2),
        .bin  (fs_bin),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, edge_cnt);
        end
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        exp_t   r;
        longint ua, ub, sa, sb, dd, sr;
        ua = longint'(va);
        ub = longint'(vb);
        dd = ua - ub;
        if (dd < 0) dd = dd + MOD;
        sa = (ua >= HALF) ? ua - MOD : ua;
        sb = (ub >= HALF) ? ub - MOD : ub;
        sr = sa - sb;
        r.d         = WIDTH'(dd);
        r.bw        = (ua < ub);
        r.ov        = (sr > HALF - 1) || (sr < -HALF);
        r.done_edge = 0;
        return r;
    endfunction

    // Monitor: compares handshake and held result every cycle.
    always @(negedge clk) begin
        int  e;
        bit  exp_busy;
        bit  exp_done;
        e        = edge_cnt;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sbq.size() > 0) begin
            exp_busy = (e >= sbq[0].done_edge - WIDTH) && (e <= sbq[0].done_edge);
            exp_done = (e == sbq[0].done_edge);
        end
        check("busy", longint'(busy), longint'(exp_busy));
        check("done", longint'(done), longint'(exp_done));
        if (exp_done) begin
            last_diff   = sbq[0].d;
            last_borrow = sbq[0].bw;
            last_ovf    = sbq[0].ov;
            void'(sbq.pop_front());
        end
        check("diff", longint'(diff), longint'(last_diff));
        check("borrow", longint'(borrow), longint'(last_borrow));
`ifdef SUB_OVF_EN
        check("ovf", longint'(ovf), longint'(last_ovf));
`endif
    end

    task automatic drive(input logic s, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        exp_t it;
        @(negedge clk);
        #1;
        start = s;
        a     = va;
        b     = vb;
        if (s && !reset && (edge_cnt + 1) >= free_edge) begin
            it           = model(va, vb);
            it.done_edge = edge_cnt + 1 + WIDTH;
            sbq.push_back(it);
            free_edge    = edge_cnt + 1 + WIDTH + 2;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        drive(1'b1, va, vb);
        idle(WIDTH + 1);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1;
        reset       = 1'b1;
        start       = 1'b0;
        sbq.delete();
        free_edge   = 0;
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        // Bit cell over all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            int ref_v;
            fs_in1 = i[2];
            fs_in2 = i[1];
            fs_bin = i[0];
            #1;
            ref_v = int'(i[2]) - int'(i[1]) - int'(i[0]);
            check("fs_diff", longint'(fs_diff), longint'(ref_v & 1));
            check("fs_bout", longint'(fs_bout), longint'(ref_v < 0));
        end

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;

        run_op(14'd9999, 14'd1234);
        run_op(14'd0, 14'd1);
        run_op(14'd5000, 14'd5000);

        // start held high with operands changing every cycle.
        repeat (3 * (WIDTH + 2) + 2) drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
        idle(WIDTH + 2);

        // Abort mid-operation, then rerun the same operands.
        drive(1'b1, 14'd100, 14'd50);
        idle(6);
        pulse_reset(1);
        idle(2);
        run_op(14'd100, 14'd50);

        // Previous result held while the next operation runs.
        run_op(14'd9999, 14'd1234);
        run_op(14'd1, 14'd2);

        // Signed-overflow corner cases.
        run_op(14'd8191, 14'd16383);
        run_op(14'd10, 14'd3);
        run_op(14'd8192, 14'd1);

        // Random operations with random gaps and stray starts while busy.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom));
            gap = $urandom_range(0, WIDTH + 4);
            for (int j = 0; j < gap; j++) begin
                drive(($urandom_range(0, 9) < 3), WIDTH'($urandom), WIDTH'($urandom));
            end
        end
        idle(WIDTH + 4);

        check("pending_results", longint'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
